// File: rtl/memory_axil_arbiter_if.sv
// memory_axil_arbiter_if: AXI-Lite bus between the arbiter (master) and the shared RAM (slave).
interface memory_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/memory_axil_arbiter.sv
// memory_axil_arbiter: shares one AXI-Lite RAM between the fetch (read-only) and data ports.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise data has fixed priority.
module memory_axil_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_n,
    input  logic                    i_Fetch_Req,
    input  logic [31:0]             i_Fetch_Addr,
    output logic [DATA_WIDTH-1:0]   o_Fetch_RData,
    output logic                    o_Fetch_Done,
    input  logic                    i_Data_Req,
    input  logic                    i_Data_Write,
    input  logic [31:0]             i_Data_Addr,
    input  logic [DATA_WIDTH-1:0]   i_Data_WData,
    input  logic [DATA_WIDTH/8-1:0] i_Data_WStrb,
    output logic [DATA_WIDTH-1:0]   o_Data_RData,
    output logic                    o_Data_Done,
    output logic                    o_Err,
    memory_axil_arbiter_if.master   axil
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_t;

    state_t                  r_State, w_Next;
    logic                    r_Grant;
    logic [ADDR_WIDTH-1:0]   r_Addr;
    logic [DATA_WIDTH-1:0]   r_WData;
    logic [DATA_WIDTH/8-1:0] r_WStrb;
    logic                    r_AW_Ok, r_W_Ok, r_Err;
    logic [DATA_WIDTH-1:0]   r_Fetch_RData, r_Data_RData;
    logic                    w_Any_Req, w_Pick_Data, w_Start;
    logic                    unused_addr_bits;

    assign w_Any_Req = i_Fetch_Req || i_Data_Req;
    assign w_Start = r_State == S_IDLE && w_Any_Req;
    assign unused_addr_bits = ^{i_Fetch_Addr[31:ADDR_WIDTH], i_Data_Addr[31:ADDR_WIDTH]};

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic r_Last_Data;
    assign w_Pick_Data = i_Data_Req && (!i_Fetch_Req || !r_Last_Data);
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            r_Last_Data <= 1'b0;
        else if (w_Start)
            r_Last_Data <= w_Pick_Data;
    end
`else
    assign w_Pick_Data = i_Data_Req;
`endif

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            r_State <= S_IDLE;
        else
            r_State <= w_Next;
    end

    always_comb begin
        w_Next = r_State;
        axil.arvalid = 1'b0;
        axil.rready = 1'b0;
        axil.awvalid = 1'b0;
        axil.wvalid = 1'b0;
        axil.bready = 1'b0;
        o_Fetch_Done = 1'b0;
        o_Data_Done = 1'b0;
        case (r_State)
            S_IDLE: w_Next = !w_Any_Req ? S_IDLE : (w_Pick_Data && i_Data_Write) ? S_AWW : S_AR;
            S_AR: begin
                axil.arvalid = 1'b1;
                w_Next = axil.arready ? S_R : S_AR;
            end
            S_R: begin
                axil.rready = 1'b1;
                w_Next = axil.rvalid ? S_DONE : S_R;
            end
            S_AWW: begin
                axil.awvalid = !r_AW_Ok;
                axil.wvalid = !r_W_Ok;
                w_Next = ((r_AW_Ok || axil.awready) && (r_W_Ok || axil.wready)) ? S_B : S_AWW;
            end
            S_B: begin
                axil.bready = 1'b1;
                w_Next = axil.bvalid ? S_DONE : S_B;
            end
            S_DONE: begin
                o_Fetch_Done = !r_Grant;
                o_Data_Done = r_Grant;
                w_Next = S_IDLE;
            end
            default: w_Next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Grant <= 1'b0;
            r_Addr <= '0;
            r_WData <= '0;
            r_WStrb <= '0;
            r_AW_Ok <= 1'b0;
            r_W_Ok <= 1'b0;
            r_Err <= 1'b0;
            r_Fetch_RData <= '0;
            r_Data_RData <= '0;
        end else begin
            if (w_Start) begin
                r_Grant <= w_Pick_Data;
                r_Addr <= w_Pick_Data ? i_Data_Addr[ADDR_WIDTH-1:0] : i_Fetch_Addr[ADDR_WIDTH-1:0];
                r_WData <= i_Data_WData;
                r_WStrb <= i_Data_WStrb;
                r_AW_Ok <= 1'b0;
                r_W_Ok <= 1'b0;
            end
            if (r_State == S_AWW && axil.awready)
                r_AW_Ok <= 1'b1;
            if (r_State == S_AWW && axil.wready)
                r_W_Ok <= 1'b1;
            if (r_State == S_R && axil.rvalid && r_Grant)
                r_Data_RData <= axil.rdata;
            if (r_State == S_R && axil.rvalid && !r_Grant)
                r_Fetch_RData <= axil.rdata;
            // error responses are recorded but never abort the transaction
            if ((r_State == S_R && axil.rvalid && axil.rresp != 2'b00) ||
                (r_State == S_B && axil.bvalid && axil.bresp != 2'b00))
                r_Err <= 1'b1;
        end
    end

    assign axil.araddr = r_Addr;
    assign axil.awaddr = r_Addr;
    assign axil.wdata = r_WData;
    assign axil.wstrb = r_WStrb;
    assign o_Fetch_RData = r_Fetch_RData;
    assign o_Data_RData = r_Data_RData;
    assign o_Err = r_Err;
endmodule

// File: tb/tb_memory_axil_arbiter.sv
// tb_memory_axil_arbiter: directed and randomized checks of the arbiter against a small RAM slave
// and a transaction-level reference model (memory image, last-served port, sticky error).
module tb_memory_axil_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic f_req = 1'b0, d_req = 1'b0, d_write = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0] d_wstrb = '0;
    logic [31:0] f_rdata, d_rdata;
    logic f_done, d_done, err;

    memory_axil_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Fetch_Req(f_req), .i_Fetch_Addr(f_addr), .o_Fetch_RData(f_rdata), .o_Fetch_Done(f_done),
        .i_Data_Req(d_req), .i_Data_Write(d_write), .i_Data_Addr(d_addr), .i_Data_WData(d_wdata),
        .i_Data_WStrb(d_wstrb), .o_Data_RData(d_rdata), .o_Data_Done(d_done), .o_Err(err),
        .axil(bus.master)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0111);
    endfunction

    // RAM slave with programmable ready delays and response codes
    int ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic [1:0] rresp_val = 2'b00, bresp_val = 2'b00;
    int ar_cnt, aw_cnt, w_cnt;
    logic aw_got, w_got, mem_loaded = 1'b0;
    logic [5:0] aw_idx;
    logic [31:0] w_data;
    logic [3:0] w_strb;
    logic [31:0] slv_mem [64];

    assign bus.arready = bus.arvalid && ar_cnt >= ar_wait;
    assign bus.awready = bus.awvalid && aw_cnt >= aw_wait;
    assign bus.wready = bus.wvalid && w_cnt >= w_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bus.rvalid <= 1'b0; bus.bvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00; bus.bresp <= 2'b00;
        end else begin
            if (!mem_loaded) begin
                for (int i = 0; i < 64; i++) slv_mem[i] <= init_word(i);
                mem_loaded <= 1'b1;
            end
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1; bus.rdata <= slv_mem[bus.araddr[7:2]]; bus.rresp <= rresp_val;
            end else if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (bus.awvalid && bus.awready) begin aw_got <= 1'b1; aw_idx <= bus.awaddr[7:2]; end
            if (bus.wvalid && bus.wready) begin w_got <= 1'b1; w_data <= bus.wdata; w_strb <= bus.wstrb; end
            if (aw_got && w_got && !bus.bvalid) begin
                bus.bvalid <= 1'b1; bus.bresp <= bresp_val; aw_got <= 1'b0; w_got <= 1'b0;
                for (int b = 0; b < 4; b++) if (w_strb[b]) slv_mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end else if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
        end
    end

    // reference model
    logic [31:0] ref_mem [64];
    bit m_last_fetch = 1'b1;
    bit m_err = 1'b0;
    int n_vec = 0, n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit expect_data(input bit f, input bit d);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        return d && (!f || m_last_fetch);
`else
        return d && (f || !f);
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    // issue requests, check every completion against the model; hold keeps requests up
    task automatic serve(input bit fr, input bit dr, input bit hold, input int ngrants, input string tag);
        int seen = 0, cyc = 0;
        bit exp_d;
        f_req = fr; d_req = dr;
        while (seen < ngrants && cyc < 200) begin
            tick; cyc++;
            if (f_done || d_done) begin
                seen++;
                exp_d = expect_data(f_req, d_req);
                check({tag, "_active"}, d_done ? d_req : f_req, 1);
                check({tag, "_port"}, {f_done, d_done}, {!exp_d, exp_d});
                if (d_done && d_write) begin
                    model_write(d_addr, d_wdata, d_wstrb);
                    m_err |= bresp_val != 2'b00;
                end else begin
                    check({tag, "_rdata"}, d_done ? d_rdata : f_rdata,
                          ref_mem[d_done ? d_addr[7:2] : f_addr[7:2]]);
                    m_err |= rresp_val != 2'b00;
                end
                m_last_fetch = f_done;
                if (!hold && d_done) d_req = 1'b0;
                if (!hold && f_done) f_req = 1'b0;
            end
        end
        check({tag, "_grants"}, seen, ngrants);
        f_req = 1'b0; d_req = 1'b0;
        tick;
        check({tag, "_pulse"}, {f_done, d_done}, 0);
        check({tag, "_err"}, err, m_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit extra;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        tick; tick;
        check("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 0);
        check("rst_done", {f_done, d_done}, 0);
        check("rst_rdata", {f_rdata, d_rdata}, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick;

        // contention with both requests held for four grants
        f_addr = 32'h0000_0080; d_addr = 32'h0000_0084; d_write = 1'b0;
        serve(1, 1, 1, 4, "t3");

        // fetch read latency from a zero-wait RAM
        d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_write = 1'b1;
        serve(0, 1, 0, 1, "t1w");
        f_addr = 32'h0000_0040; f_req = 1'b1;
        tick;
        check("t1_araddr", {bus.arvalid, bus.araddr}, {1'b1, 16'h0040});
        check("t1_done_c1", f_done, 0);
        tick;
        check("t1_done_c2", f_done, 0);
        tick;
        check("t1_done_c3", f_done, 1);
        check("t1_rdata", f_rdata, 32'hDEAD_BEEF);
        m_last_fetch = 1'b1;
        f_req = 1'b0;
        tick;
        check("t1_pulse", f_done, 0);

        // write with awready two cycles ahead of wready
        aw_wait = 1; w_wait = 3;
        d_addr = 32'h0000_0010; d_wdata = 32'h0000_AB00; d_wstrb = 4'b0010; d_write = 1'b1; d_req = 1'b1;
        tick;
        check("t2_both_valid", {bus.awvalid, bus.wvalid}, 2'b11);
        tick; tick;
        check("t2_aw_first", {bus.awvalid, bus.wvalid}, 2'b01);
        serve(0, 1, 0, 1, "t2");
        aw_wait = 0; w_wait = 0; d_write = 1'b0;
        serve(0, 1, 0, 1, "t2rd");
        check("t2_byte1", d_rdata[15:8], 8'hAB);

        // error response on a fetch
        rresp_val = 2'b10; f_addr = 32'h0000_0044;
        serve(1, 0, 0, 1, "t4");
        check("t4_err_set", err, 1);
        rresp_val = 2'b00; d_addr = 32'h0000_0048;
        serve(0, 1, 0, 1, "t4b");
        check("t4_err_sticky", err, 1);

        // data request dropped while in R
        d_addr = 32'h0000_0048; d_write = 1'b0; d_req = 1'b1;
        tick; tick;
        check("t6_in_r", bus.rready, 1);
        d_req = 1'b0;
        tick;
        check("t6_done", d_done, 1);
        check("t6_rdata", d_rdata, ref_mem[18]);
        m_last_fetch = 1'b0;
        extra = 1'b0;
        repeat (4) begin tick; extra |= d_done | bus.arvalid | bus.awvalid; end
        check("t6_no_second", extra, 0);

        // reset in the middle of a write
        aw_wait = 10; w_wait = 10;
        d_addr = 32'h0000_004C; d_wdata = 32'h1234_5678; d_wstrb = 4'hF; d_write = 1'b1; d_req = 1'b1;
        tick;
        check("t5_in_aww", {bus.awvalid, bus.wvalid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_drop", {bus.awvalid, bus.wvalid}, 2'b00);
        check("t5_err_clear", err, 0);
        d_req = 1'b0;
        tick;
        check("t5_no_done", {f_done, d_done}, 0);
        rst_n = 1'b1; m_last_fetch = 1'b1; m_err = 1'b0;
        aw_wait = 0; w_wait = 0; d_write = 1'b0;
        tick;
        serve(0, 1, 0, 1, "t5rd");

        // randomized traffic
        repeat (40) begin
            bit fr, dr;
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1)) | !fr;
            ar_wait = $urandom_range(0, 3); aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            rresp_val = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            bresp_val = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
            f_addr = {16'($urandom), 8'h00, 6'($urandom), 2'b00};
            d_addr = {16'($urandom), 8'h00, 6'($urandom), 2'b00};
            d_write = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
            serve(fr, dr, 0, int'(fr) + int'(dr), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
